// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter register and instruction-fetch sequencer
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic        halt,
  output logic        misalign_exc,
  output logic [31:0] exc_pc,
  output logic [31:0] retire_count,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, WAIT = 2'd2, HALTED = 2'd3} state_t;
  state_t      cur, nxt;
  logic [31:0] pc, pc_next;
  logic        pending_trap, retire, take_trap, misaligned;
  assign imem_req    = (cur == FETCH) || (cur == WAIT);
  assign instr_valid = imem_req & imem_ready;
  assign retire      = instr_valid;
  assign take_trap   = trap_req | pending_trap;
  assign misaligned  = branch_taken & (branch_target[1:0] != 2'b00);
  assign pc_out      = pc;
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign state       = cur;
  // next state and next pc; redirect priority is trap, misaligned target, branch, sequential
  always_comb begin
    nxt     = cur;
    pc_next = pc;
    if (cur == BOOT) nxt = FETCH;
    else if (imem_req) nxt = !imem_ready ? WAIT : (halt ? HALTED : FETCH);
    if (retire)
      pc_next = (take_trap || misaligned) ? TRAP_VECTOR : (branch_taken ? branch_target : pc_plus4);
  end
  // fsm state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= BOOT;
    else cur <= nxt;
  end
  // pc, trap latch, exception reporting and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_VECTOR;
      pending_trap <= 1'b0;
      misalign_exc <= 1'b0;
      exc_pc       <= 32'd0;
      retire_count <= 32'd0;
    end else begin
      pc           <= pc_next;
      pending_trap <= retire ? 1'b0 : (pending_trap | (trap_req & (cur != HALTED)));
      misalign_exc <= retire & ~take_trap & misaligned;
      if (retire && (take_trap || misaligned)) exc_pc <= pc;
      if (retire) retire_count <= retire_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test of pc_sequencer against a rule-level reference model
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready = 1'b0, instr_valid, misalign_exc;
  logic        branch_taken = 1'b0, trap_req = 1'b0, halt = 1'b0;
  logic [31:0] imem_addr, pc_out, pc_plus4, branch_target = 32'd0, exc_pc, retire_count;
  logic [1:0]  state;
  int          n_cmp = 0, n_err = 0;
  bit          go = 1'b0;
  logic [31:0] m_pc = RV, m_exc = 32'd0, m_cnt = 32'd0;
  bit          m_boot = 1'b1, m_halt = 1'b0, m_wait = 1'b0, m_pend = 1'b0, m_mis = 1'b0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .instr_valid(instr_valid), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_req(trap_req), .halt(halt), .misalign_exc(misalign_exc), .exc_pc(exc_pc),
    .retire_count(retire_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: one instruction per ready cycle, traps latched while stalled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RV; m_boot <= 1'b1; m_halt <= 1'b0; m_wait <= 1'b0;
      m_pend <= 1'b0; m_mis <= 1'b0; m_exc <= 32'd0; m_cnt <= 32'd0;
    end else begin
      m_mis <= 1'b0;
      if (m_boot) begin
        m_boot <= 1'b0;
        m_pend <= m_pend | trap_req;
      end else if (!m_halt) begin
        if (!imem_ready) begin
          m_wait <= 1'b1;
          if (trap_req) m_pend <= 1'b1;
        end else begin
          m_cnt  <= m_cnt + 1;
          m_wait <= 1'b0;
          m_halt <= halt;
          m_pend <= 1'b0;
          if (trap_req || m_pend) begin
            m_exc <= m_pc; m_pc <= TV;
          end else if (branch_taken && (branch_target % 4 != 0)) begin
            m_exc <= m_pc; m_pc <= TV; m_mis <= 1'b1;
          end else m_pc <= branch_taken ? branch_target : m_pc + 4;
        end
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (go) begin
      logic [1:0] es;
      logic       act;
      es  = m_boot ? 2'd0 : m_halt ? 2'd3 : m_wait ? 2'd2 : 2'd1;
      act = !m_boot && !m_halt;
      chk("m_state", {30'd0, state}, {30'd0, es});
      chk("m_pc", pc_out, m_pc);
      chk("m_addr", imem_addr, m_pc);
      chk("m_plus4", pc_plus4, m_pc + 32'd4);
      chk("m_req", {31'd0, imem_req}, {31'd0, act});
      chk("m_valid", {31'd0, instr_valid}, {31'd0, act & imem_ready});
      chk("m_mis", {31'd0, misalign_exc}, {31'd0, m_mis});
      chk("m_exc", exc_pc, m_exc);
      chk("m_cnt", retire_count, m_cnt);
    end
  end

  task automatic cyc(input logic r, input logic bt, input logic [31:0] tg,
                     input logic tr, input logic h);
    imem_ready = r; branch_taken = bt; branch_target = tg; trap_req = tr; halt = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    go = 1'b1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("boot_fetch", {30'd0, state}, 32'd1);
    chk("boot_pc", pc_out, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("seq_pc4", pc_out, 32'h4);
    cyc(1, 0, 0, 0, 0);
    chk("seq_pc8", pc_out, 32'h8);
    repeat (3) begin
      cyc(0, 1, 32'h40, 0, 0);
      chk("wait_state", {30'd0, state}, 32'd2);
      chk("wait_pc", pc_out, 32'h8);
    end
    cyc(1, 0, 0, 0, 0);
    chk("wait_ret_pc", pc_out, 32'hC);
    chk("cnt3", retire_count, 32'd3);
    cyc(1, 1, 32'h40, 0, 0);
    chk("br_pc", pc_out, 32'h40);
    cyc(1, 1, 32'h42, 0, 0);
    chk("mis_pc", pc_out, TV);
    chk("mis_pulse", {31'd0, misalign_exc}, 32'd1);
    chk("mis_exc", exc_pc, 32'h40);
    cyc(1, 1, 32'h41, 0, 0);
    chk("mis0_pc", pc_out, TV);
    chk("mis0_exc", exc_pc, TV);
    cyc(1, 1, 32'h10, 0, 0);
    chk("mis_clear", {31'd0, misalign_exc}, 32'd0);
    chk("to10", pc_out, 32'h10);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("trapwait_pc", pc_out, 32'h10);
    cyc(1, 1, 32'h40, 0, 0);
    chk("ptrap_pc", pc_out, TV);
    chk("ptrap_exc", exc_pc, 32'h10);
    cyc(1, 1, 32'h20, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("halt_pc", pc_out, 32'h24);
    chk("halt_state", {30'd0, state}, 32'd3);
    repeat (2) cyc(1, 1, 32'h80, 1, 0);
    chk("halted_pc", pc_out, 32'h24);
    chk("halted_req", {31'd0, imem_req}, 32'd0);
    chk("halted_cnt", retire_count, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("hrst_pc", pc_out, 32'h0);
    chk("hrst_state", {30'd0, state}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("boot_trap_pc", pc_out, TV);
    chk("boot_trap_exc", exc_pc, 32'h0);
    cyc(1, 1, 32'hFFFF_FFFC, 0, 0);
    chk("top_pc", pc_out, 32'hFFFF_FFFC);
    chk("top_plus4", pc_plus4, 32'h0);
    cyc(1, 0, 0, 0, 0);
    chk("wrap_pc", pc_out, 32'h0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre_rst_state", {30'd0, state}, 32'd2);
    #2;
    imem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_cnt", retire_count, 32'd0);
    chk("arst_exc", exc_pc, 32'd0);
    chk("arst_mis", {31'd0, misalign_exc}, 32'd0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter register and sequences instruction fetch.
- Each retire cycle it selects the next PC from three sources: sequential (PC+4), branch/jump target, or trap vector.
- Handles a variable-latency instruction-memory ready handshake, latches traps that arrive while a fetch is stalled, detects misaligned branch targets, and supports halt.
- Sits between the branch/decode logic and instruction memory, and replaces ad-hoc next-PC muxing in the core top level.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a trap or a misaligned-target exception.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request; high in FETCH and WAIT.
- imem_addr  output  32  fetch address; always equals pc_out.
- imem_ready  input  1  instruction memory has valid data this cycle.
- instr_valid  output  1  combinational imem_req & imem_ready; marks the retire cycle.
- pc_out  output  32  current PC.
- pc_plus4  output  32  pc_out + 4, modulo 2^32.
- branch_taken  input  1  branch/jump taken; sampled only on retire.
- branch_target  input  32  redirect target; sampled only on retire.
- trap_req  input  1  trap request, single-cycle pulse permitted in any state.
- halt  input  1  stop after the current instruction; sampled only on retire.
- misalign_exc  output  1  registered one-cycle pulse on a misaligned branch target.
- exc_pc  output  32  PC of the instruction that trapped or misaligned.
- retire_count  output  32  number of retired instructions.
- state  output  2  FSM state: BOOT=0, FETCH=1, WAIT=2, HALTED=3.

Behaviour:
- Reset (asynchronous, rst_n low), applied immediately and also mid-fetch:
  - pc=RESET_VECTOR, state=BOOT, pending_trap=0, misalign_exc=0, exc_pc=0, retire_count=0.
  - imem_req=0 and instr_valid=0, since both derive from state.
- BOOT: unconditionally goes to FETCH on the next edge. No request is issued in BOOT.
- FETCH/WAIT:
  - imem_req=1.
  - If imem_ready=0: next state is WAIT and pc holds.
  - If imem_ready=1 (retire): next state is FETCH, or HALTED if halt=1; pc updates and retire_count increments (wraps at 2^32).
- Next-PC priority on retire, highest first:
  1. trap_req | pending_trap: pc<=TRAP_VECTOR, exc_pc<=pc, pending_trap<=0.
  2. branch_taken & branch_target[1:0]!=0: pc<=TRAP_VECTOR, exc_pc<=pc, misalign_exc<=1 for exactly one cycle.
  3. branch_taken: pc<=branch_target.
  4. Otherwise: pc<=pc+4. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- pending_trap:
  - Set when trap_req=1 on a non-retire cycle in FETCH, WAIT or BOOT.
  - Cleared when consumed on retire.
  - A trap in HALTED is ignored.
- halt together with a redirect on the same retire: the redirect is applied to pc first, then the FSM enters HALTED.
- HALTED:
  - imem_req=0, pc frozen, all inputs ignored.
  - Exits only via reset.
- branch_taken and branch_target are don't-care on non-retire cycles. branch_target[1] misalignment is an exception (no compressed-instruction support).
- misalign_exc is 0 on every cycle except the one following a misaligned retire.
- Outputs pc_out, imem_addr and pc_plus4 are combinational from the pc register. There are no combinational paths from imem_ready to pc_out.

Test Plan:
- Reset then imem_ready=1 held: state BOOT→FETCH. Addresses 0x0, 0x4, 0x8 are fetched on consecutive cycles, and retire_count reaches 3 after 3 retires.
- imem_ready low for 3 cycles at pc=0x8: state=WAIT and pc holds at 0x8 throughout. On ready, the instruction retires and pc becomes 0xC.
- Retire with branch_taken=1, branch_target=0x40: next pc=0x40. With branch_target=0x42: pc=0x100, misalign_exc pulses once, exc_pc=old pc.
- trap_req pulsed during WAIT at pc=0x10, branch_taken=1 at the retire: pending trap wins, so pc=0x100 and exc_pc=0x10.
- halt=1 at the retire of pc=0x20: pc=0x24 and state=HALTED. Subsequent imem_ready, trap_req and branch inputs do not change pc. rst_n low restores pc=0x0 and state=BOOT.
- pc forced to 0xFFFF_FFFC via branch_target, then a sequential retire: pc wraps to 0x0000_0000. Assert rst_n low mid-WAIT: all outputs return to reset values asynchronously.
